// File: rtl/arch_map_table.sv
// Committed arch->phys map: frees superseded tags one cycle after commit; on recovery streams the map (busy blocks commits).
// Define ARCH_MAP_FULL_RESTORE_EN to restore the whole table in one cycle instead of RESTORE_WIDTH-entry chunks.
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif
`ifndef N
`define N 2
`endif
`ifndef PHYS_TAG_W
`define PHYS_TAG_W 7
`endif

module arch_map_table #(
   parameter int  NUM_COMMIT_PORTS = `N,
   parameter int  RESTORE_WIDTH    = 8,
   localparam int ARCH_REGS        = `ARCH_REG_SZ,
   localparam int REG_W            = $clog2(`ARCH_REG_SZ),
   localparam int TAG_W            = `PHYS_TAG_W,
`ifdef ARCH_MAP_FULL_RESTORE_EN
   localparam int OUT_W            = `ARCH_REG_SZ
`else
   localparam int OUT_W            = RESTORE_WIDTH
`endif
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic [NUM_COMMIT_PORTS-1:0]             commit_valid,
   input  logic [NUM_COMMIT_PORTS-1:0][REG_W-1:0]  commit_arch_reg,
   input  logic [NUM_COMMIT_PORTS-1:0][TAG_W-1:0]  commit_phys_reg,
   output logic [NUM_COMMIT_PORTS-1:0]             free_valid,
   output logic [NUM_COMMIT_PORTS-1:0][TAG_W-1:0]  free_tag,
   input  logic                                    recover_req,
   output logic                                    busy,
   output logic                                    restore_valid,
   output logic [REG_W-1:0]                        restore_base,
   output logic [OUT_W-1:0][TAG_W-1:0]             restore_tags,
   output logic                                    restore_done
);

   localparam int NUM_CHUNKS = ARCH_REGS / OUT_W;
   localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   typedef enum logic {S_IDLE, S_RESTORE} state_t;

   state_t                                r_state;
   state_t                                w_state_nxt;
   logic [ARCH_REGS-1:0][TAG_W-1:0]       r_table;
   logic [ARCH_REGS-1:0][TAG_W-1:0]       w_table_nxt;
   logic [NUM_COMMIT_PORTS-1:0]           w_free_vld;
   logic [NUM_COMMIT_PORTS-1:0][TAG_W-1:0] w_free_tag;
   logic [CNT_W-1:0]                      r_chunk;
   logic                                  w_last_chunk;
   logic                                  w_commit_en;

   assign w_commit_en  = (r_state == S_IDLE);
   assign w_last_chunk = (r_chunk == CNT_W'(NUM_CHUNKS - 1));

   // Walking ports oldest-first gives intra-group forwarding and youngest-write-wins.
   always_comb begin
      w_table_nxt = r_table;
      w_free_vld  = '0;
      w_free_tag  = '0;
      for (int p = 0; p < NUM_COMMIT_PORTS; p++) begin
         if (w_commit_en && commit_valid[p] && (commit_arch_reg[p] != '0)) begin
            w_free_vld[p]                   = 1'b1;
            w_free_tag[p]                   = w_table_nxt[commit_arch_reg[p]];
            w_table_nxt[commit_arch_reg[p]] = commit_phys_reg[p];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            r_table[i] <= TAG_W'(i);
         end
         free_valid <= '0;
         free_tag   <= '0;
         r_chunk    <= '0;
      end else begin
         r_table    <= w_table_nxt;
         free_valid <= w_free_vld;
         free_tag   <= w_free_tag;
         if (r_state == S_RESTORE) begin
            r_chunk <= w_last_chunk ? '0 : r_chunk + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A recover_req arriving while already restoring is dropped.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (recover_req)  w_state_nxt = S_RESTORE;
         S_RESTORE: if (w_last_chunk) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = 1'b0;
      restore_valid = 1'b0;
      restore_done  = 1'b0;
      restore_base  = '0;
      restore_tags  = '0;
      if (r_state == S_RESTORE) begin
         busy          = 1'b1;
         restore_valid = 1'b1;
         restore_done  = w_last_chunk;
         restore_base  = REG_W'(int'(r_chunk) * OUT_W);
         for (int j = 0; j < OUT_W; j++) begin
            restore_tags[j] = r_table[REG_W'(int'(r_chunk) * OUT_W + j)];
         end
         // x0 is hardwired; never let a stale tag leak out for it.
         if (r_chunk == '0) begin
            restore_tags[0] = '0;
         end
      end
   end

endmodule

// File: tb/tb_arch_map_table.sv
// Randomized + directed bench for arch_map_table against an array-based committed-map model.
module tb_arch_map_table;
   localparam int NP = 2, AR = 32, RW = 8, TW = 7, C = AR / RW;

   logic                     clock = 1'b0;
   logic                     reset;
   logic [NP-1:0]            commit_valid;
   logic [NP-1:0][4:0]       commit_arch_reg;
   logic [NP-1:0][TW-1:0]    commit_phys_reg;
   logic [NP-1:0]            free_valid;
   logic [NP-1:0][TW-1:0]    free_tag;
   logic                     recover_req;
   logic                     busy, restore_valid, restore_done;
   logic [4:0]               restore_base;
   logic [RW-1:0][TW-1:0]    restore_tags;

   int checks = 0, errors = 0;
   int model[AR];
   logic [NP-1:0] exp_fv;
   int exp_ft[NP];

   arch_map_table #(.NUM_COMMIT_PORTS(NP), .RESTORE_WIDTH(RW)) dut (
      .clock(clock), .reset(reset),
      .commit_valid(commit_valid), .commit_arch_reg(commit_arch_reg), .commit_phys_reg(commit_phys_reg),
      .free_valid(free_valid), .free_tag(free_tag), .recover_req(recover_req),
      .busy(busy), .restore_valid(restore_valid), .restore_base(restore_base),
      .restore_tags(restore_tags), .restore_done(restore_done));

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (busy === 1'b1 && commit_valid !== '0) begin
         errors++;
         $display("FAIL protocol: commit_valid=%b while busy=1, required 0", commit_valid);
      end
   end

   task automatic tick(); @(posedge clock); #1; endtask

   task automatic clear_inputs();
      commit_valid = '0; commit_arch_reg = '0; commit_phys_reg = '0; recover_req = 1'b0;
   endtask

   task automatic drive(input int p, input int a, input int t);
      commit_valid[p] = 1'b1; commit_arch_reg[p] = 5'(a); commit_phys_reg[p] = TW'(t);
   endtask

   task automatic model_reset();
      for (int i = 0; i < AR; i++) model[i] = i;
   endtask

   // Committed-map rules: in-order ports, x0 and invalid ports ignored.
   task automatic model_commit();
      exp_fv = '0;
      for (int p = 0; p < NP; p++) begin
         exp_ft[p] = 0;
         if (commit_valid[p] && commit_arch_reg[p] != 0) begin
            exp_fv[p] = 1'b1;
            exp_ft[p] = model[commit_arch_reg[p]];
            model[commit_arch_reg[p]] = int'(commit_phys_reg[p]);
         end
      end
   endtask

   task automatic test_reset();
      clear_inputs(); reset = 1'b1;
      tick(); tick();
      checks++;
      if (free_valid !== '0 || free_tag !== '0 || busy !== 1'b0 || restore_valid !== 1'b0 ||
          restore_base !== '0 || restore_tags !== '0 || restore_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: fv=%b ft=%h busy=%b rv=%b base=%0d tags=%h done=%b, required all 0",
                  free_valid, free_tag, busy, restore_valid, restore_base, restore_tags, restore_done);
      end
      reset = 1'b0; model_reset();
      recover_req = 1'b1; tick(); recover_req = 1'b0;
      for (int k = 0; k < C; k++) begin
         checks++;
         if (busy !== 1'b1 || restore_valid !== 1'b1 || restore_base !== 5'(k * RW) || restore_done !== (k == C - 1)) begin
            errors++;
            $display("FAIL reset_restore_ctl k=%0d: busy=%b rv=%b base=%0d done=%b, required 1 1 %0d %0d",
                     k, busy, restore_valid, restore_base, restore_done, k * RW, k == C - 1);
         end
         for (int j = 0; j < RW; j++) begin
            checks++;
            if (restore_tags[j] !== TW'(k * RW + j)) begin
               errors++;
               $display("FAIL reset_restore_tag k=%0d j=%0d: got %0d, required %0d", k, j, restore_tags[j], k * RW + j);
            end
         end
         tick();
      end
      checks++;
      if (busy !== 1'b0 || restore_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_restore_end: busy=%b rv=%b, required 0 0", busy, restore_valid);
      end
   endtask

   task automatic test_single_commit();
      drive(0, 5, 40); model_commit(); tick(); clear_inputs();
      checks++;
      if (free_valid !== 2'b01 || free_tag[0] !== TW'(5)) begin
         errors++;
         $display("FAIL single_first: fv=%b tag0=%0d, required 01 5", free_valid, free_tag[0]);
      end
      drive(0, 5, 41); model_commit(); tick(); clear_inputs();
      checks++;
      if (free_valid !== 2'b01 || free_tag[0] !== TW'(40)) begin
         errors++;
         $display("FAIL single_second: fv=%b tag0=%0d, required 01 40", free_valid, free_tag[0]);
      end
      tick();
      checks++;
      if (free_valid !== 2'b00) begin
         errors++;
         $display("FAIL single_idle: fv=%b, required 00", free_valid);
      end
   endtask

   task automatic test_same_reg();
      drive(0, 7, 50); drive(1, 7, 51); model_commit(); tick(); clear_inputs();
      checks++;
      if (free_valid !== 2'b11 || free_tag[0] !== TW'(7) || free_tag[1] !== TW'(50)) begin
         errors++;
         $display("FAIL same_reg_free: fv=%b tag0=%0d tag1=%0d, required 11 7 50", free_valid, free_tag[0], free_tag[1]);
      end
      recover_req = 1'b1; tick(); recover_req = 1'b0;
      checks++;
      if (restore_valid !== 1'b1 || restore_base !== 5'd0 || restore_tags[7] !== TW'(51)) begin
         errors++;
         $display("FAIL same_reg_restore: rv=%b base=%0d entry7=%0d, required 1 0 51", restore_valid, restore_base, restore_tags[7]);
      end
      for (int k = 0; k < C; k++) tick();
   endtask

   task automatic test_x0();
      drive(0, 0, 60); model_commit(); tick(); clear_inputs();
      checks++;
      if (free_valid !== 2'b00) begin
         errors++;
         $display("FAIL x0_free: fv=%b, required 00", free_valid);
      end
      recover_req = 1'b1; tick(); recover_req = 1'b0;
      checks++;
      if (restore_valid !== 1'b1 || restore_tags[0] !== '0) begin
         errors++;
         $display("FAIL x0_restore: rv=%b entry0=%0d, required 1 0", restore_valid, restore_tags[0]);
      end
      for (int k = 0; k < C; k++) tick();
   endtask

   task automatic test_recover_commit();
      int nbusy = 0, nchunks = 0;
      drive(0, 3, 45); recover_req = 1'b1; model_commit(); tick(); clear_inputs();
      checks++;
      if (free_valid !== 2'b01 || free_tag[0] !== TW'(3)) begin
         errors++;
         $display("FAIL recover_free: fv=%b tag0=%0d, required 01 3", free_valid, free_tag[0]);
      end
      checks++;
      if (restore_base !== 5'd0 || restore_tags[3] !== TW'(45)) begin
         errors++;
         $display("FAIL recover_entry3: base=%0d entry3=%0d, required 0 45", restore_base, restore_tags[3]);
      end
      for (int c = 0; c < C + 3; c++) begin
         if (busy === 1'b1) nbusy++;
         if (restore_valid === 1'b1) nchunks++;
         recover_req = (c == 1);
         tick();
      end
      recover_req = 1'b0;
      checks++;
      if (nbusy != C || nchunks != C) begin
         errors++;
         $display("FAIL recover_len: busy cycles=%0d chunks=%0d, required %0d %0d", nbusy, nchunks, C, C);
      end
   endtask

   task automatic test_reset_mid_restore();
      recover_req = 1'b1; tick(); recover_req = 1'b0; tick();
      checks++;
      if (restore_valid !== 1'b1 || restore_base !== 5'(RW)) begin
         errors++;
         $display("FAIL midrst_chunk1: rv=%b base=%0d, required 1 %0d", restore_valid, restore_base, RW);
      end
      reset = 1'b1; tick(); reset = 1'b0; model_reset();
      checks++;
      if (restore_valid !== 1'b0 || busy !== 1'b0 || restore_done !== 1'b0 || restore_tags !== '0) begin
         errors++;
         $display("FAIL midrst_abort: rv=%b busy=%b done=%b, required 0 0 0", restore_valid, busy, restore_done);
      end
      tick();
      checks++;
      if (restore_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_nomore: rv=%b busy=%b, required 0 0", restore_valid, busy);
      end
      recover_req = 1'b1; tick(); recover_req = 1'b0;
      for (int k = 0; k < C; k++) begin
         for (int j = 0; j < RW; j++) begin
            checks++;
            if (restore_tags[j] !== TW'(k * RW + j)) begin
               errors++;
               $display("FAIL midrst_identity k=%0d j=%0d: got %0d, required %0d", k, j, restore_tags[j], k * RW + j);
            end
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 300; it++) begin
         bit rec;
         rec = ($urandom_range(0, 15) == 0);
         for (int p = 0; p < NP; p++) begin
            commit_valid[p]    = 1'($urandom);
            commit_arch_reg[p] = 5'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, AR - 1));
            commit_phys_reg[p] = TW'($urandom);
         end
         recover_req = rec;
         model_commit(); tick(); clear_inputs();
         for (int p = 0; p < NP; p++) begin
            checks++;
            if (free_valid[p] !== exp_fv[p] || (exp_fv[p] && free_tag[p] !== TW'(exp_ft[p]))) begin
               errors++;
               $display("FAIL rand_free it=%0d p=%0d: fv=%b tag=%0d, required %b %0d",
                        it, p, free_valid[p], free_tag[p], exp_fv[p], exp_ft[p]);
            end
         end
         if (rec) begin
            for (int k = 0; k < C; k++) begin
               checks++;
               if (restore_valid !== 1'b1 || restore_base !== 5'(k * RW) || restore_done !== (k == C - 1)) begin
                  errors++;
                  $display("FAIL rand_restore_ctl it=%0d k=%0d: rv=%b base=%0d done=%b, required 1 %0d %0d",
                           it, k, restore_valid, restore_base, restore_done, k * RW, k == C - 1);
               end
               for (int j = 0; j < RW; j++) begin
                  int e;
                  e = (k * RW + j == 0) ? 0 : model[k * RW + j];
                  checks++;
                  if (restore_tags[j] !== TW'(e)) begin
                     errors++;
                     $display("FAIL rand_restore_tag it=%0d k=%0d j=%0d: got %0d, required %0d", it, k, j, restore_tags[j], e);
                  end
               end
               tick();
            end
         end
      end
   endtask

   initial begin
      clear_inputs(); reset = 1'b1; model_reset();
      test_reset();
      test_single_commit();
      test_same_reg();
      test_x0();
      test_recover_commit();
      test_reset_mid_restore();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
